// File: rtl/alu_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mdu_seq
// Description : Sequential execute-stage ALU with RV32I base ops (1 cycle) and
//               optional RV32M multiply/divide (iterative, one bit per cycle)
//               behind valid/ready handshakes, with pipeline flush.
//               Optional macro: ALU_MDU_MULDIV_EN enables codes 16-23;
//               without it those codes complete as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mdu_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] opdA,
   input  logic [WIDTH-1:0] opdB,
   input  logic [4:0]       op_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_illegal
);

   localparam int SH_W = $clog2(WIDTH);

   localparam logic [4:0] OP_ADD    = 5'd0;
   localparam logic [4:0] OP_SUB    = 5'd1;
   localparam logic [4:0] OP_XOR    = 5'd2;
   localparam logic [4:0] OP_OR     = 5'd3;
   localparam logic [4:0] OP_AND    = 5'd4;
   localparam logic [4:0] OP_SLL    = 5'd5;
   localparam logic [4:0] OP_SRL    = 5'd6;
   localparam logic [4:0] OP_SRA    = 5'd7;
   localparam logic [4:0] OP_SLT    = 5'd8;
   localparam logic [4:0] OP_SLTU   = 5'd9;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
`ifdef ALU_MDU_MULDIV_EN
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
`endif
      S_DONE = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [SH_W-1:0]  shamt;
   logic [WIDTH-1:0] base_res;
   logic             base_ill;

   assign shamt = opdB[SH_W-1:0];

`ifdef ALU_MDU_MULDIV_EN
   localparam logic [4:0] OP_MUL    = 5'd16;
   localparam logic [4:0] OP_MULH   = 5'd17;
   localparam logic [4:0] OP_MULHSU = 5'd18;
   localparam logic [4:0] OP_MULHU  = 5'd19;
   localparam logic [4:0] OP_DIV    = 5'd20;
   localparam logic [4:0] OP_DIVU   = 5'd21;
   localparam logic [4:0] OP_REM    = 5'd22;
   localparam logic [4:0] OP_REMU   = 5'd23;
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

   logic                 is_mul, is_div;
   logic                 sa, sb, div_ovf, div_special;
   logic [WIDTH-1:0]     a_mag, b_mag, special_res;
   logic [CNT_W-1:0]     cnt;
   logic [4:0]           op;
   logic                 neg, neg_r;
   logic [2*WIDTH-1:0]   mcand, prod, prod_nxt, prod_fix;
   logic [WIDTH-1:0]     mplier, quo, rem, dvs;
   logic [WIDTH:0]       trial, diff;
   logic                 ge;
   logic [WIDTH-1:0]     rem_nxt, quo_nxt, q_fix, r_fix;

   // Operand signs, magnitudes and the divide cases that resolve at accept
   always_comb begin
      sa = 1'b0;
      sb = 1'b0;
      case (op_sel)
         OP_MULH, OP_DIV, OP_REM: begin
            sa = opdA[WIDTH-1];
            sb = opdB[WIDTH-1];
         end
         OP_MULHSU: sa = opdA[WIDTH-1];
         default: ;
      endcase
      a_mag       = sa ? -opdA : opdA;
      b_mag       = sb ? -opdB : opdB;
      div_ovf     = (op_sel == OP_DIV || op_sel == OP_REM) && (opdA == MIN_VAL) && (opdB == '1);
      div_special = is_div && ((opdB == '0) || div_ovf);
      // op_sel[1] separates REM/REMU from DIV/DIVU; an overflowing quotient equals opdA (MIN)
      if (opdB == '0) special_res = op_sel[1] ? opdA : '1;
      else            special_res = op_sel[1] ? '0 : opdA;
   end

   // One shift-add step and one restoring-divide step, with final sign fix-up
   always_comb begin
      prod_nxt = prod + (mplier[0] ? mcand : '0);
      prod_fix = neg ? -prod_nxt : prod_nxt;
      trial    = {rem, quo[WIDTH-1]};
      diff     = trial - {1'b0, dvs};
      ge       = ~diff[WIDTH];
      rem_nxt  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_nxt  = {quo[WIDTH-2:0], ge};
      q_fix    = neg ? -quo_nxt : quo_nxt;
      r_fix    = neg_r ? -rem_nxt : rem_nxt;
   end
`endif

   // Single-cycle results and op classification
   always_comb begin
      base_res = '0;
      base_ill = 1'b0;
`ifdef ALU_MDU_MULDIV_EN
      is_mul   = 1'b0;
      is_div   = 1'b0;
`endif
      case (op_sel)
         OP_ADD:  base_res = opdA + opdB;
         OP_SUB:  base_res = opdA - opdB;
         OP_XOR:  base_res = opdA ^ opdB;
         OP_OR:   base_res = opdA | opdB;
         OP_AND:  base_res = opdA & opdB;
         OP_SLL:  base_res = opdA << shamt;
         OP_SRL:  base_res = opdA >> shamt;
         OP_SRA:  base_res = $signed(opdA) >>> shamt;
         OP_SLT:  base_res = {{(WIDTH-1){1'b0}}, ($signed(opdA) < $signed(opdB))};
         OP_SLTU: base_res = {{(WIDTH-1){1'b0}}, (opdA < opdB)};
`ifdef ALU_MDU_MULDIV_EN
         OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: is_mul = 1'b1;
         OP_DIV, OP_DIVU, OP_REM, OP_REMU:     is_div = 1'b1;
`endif
         default: base_ill = 1'b1;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state and handshake outputs; flush overrides every transition
   always_comb begin
      state_nxt = state;
      in_ready  = (state == S_IDLE);
      out_valid = (state == S_DONE);
      case (state)
         S_IDLE: begin
            if (in_valid) begin
`ifdef ALU_MDU_MULDIV_EN
               if (is_mul)                       state_nxt = S_MUL;
               else if (is_div && !div_special)  state_nxt = S_DIV;
               else                              state_nxt = S_DONE;
`else
               state_nxt = S_DONE;
`endif
            end
         end
`ifdef ALU_MDU_MULDIV_EN
         S_MUL:   if (cnt == LAST) state_nxt = S_DONE;
         S_DIV:   if (cnt == LAST) state_nxt = S_DONE;
`endif
         S_DONE:  if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (flush) state_nxt = S_IDLE;
   end

   // Datapath: capture on accept, iterate while busy, hold result in DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         out         <= '0;
         out_illegal <= 1'b0;
`ifdef ALU_MDU_MULDIV_EN
         cnt    <= '0;
         op     <= '0;
         neg    <= 1'b0;
         neg_r  <= 1'b0;
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
         quo    <= '0;
         rem    <= '0;
         dvs    <= '0;
`endif
      end else if (flush) begin
         out         <= '0;
         out_illegal <= 1'b0;
`ifdef ALU_MDU_MULDIV_EN
         cnt         <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  out         <= base_res;
                  out_illegal <= base_ill;
`ifdef ALU_MDU_MULDIV_EN
                  op     <= op_sel;
                  cnt    <= '0;
                  neg    <= sa ^ sb;
                  neg_r  <= sa;
                  mcand  <= {{WIDTH{1'b0}}, a_mag};
                  mplier <= b_mag;
                  prod   <= '0;
                  quo    <= a_mag;
                  rem    <= '0;
                  dvs    <= b_mag;
                  if (div_special) out <= special_res;
`endif
               end
            end
`ifdef ALU_MDU_MULDIV_EN
            S_MUL: begin
               prod   <= prod_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST)
                  out <= (op == OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
            end
            S_DIV: begin
               quo <= quo_nxt;
               rem <= rem_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) out <= op[1] ? r_fix : q_fix;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mdu_seq
// Description : Self-checking bench for alu_mdu_seq (WIDTH=32). Expected
//               results come from an arithmetic reference model; honours
//               ALU_MDU_MULDIV_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mdu_seq;

   localparam int W = 32;
   localparam logic [31:0] MINV = 32'h8000_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  opdA = '0;
   logic [W-1:0]  opdB = '0;
   logic [4:0]    op_sel = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out;
   logic          out_illegal;

   int tests_run = 0;
   int tests_failed = 0;

   alu_mdu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .opdA(opdA), .opdB(opdB), .op_sel(op_sel),
      .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   // Reference model: result, illegal flag and accept-to-valid latency
   function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ill, output int lat);
      logic signed [63:0] sa, sb, p;
      logic [63:0] up;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      r = '0; ill = 1'b0; lat = 1; p = '0; up = '0;
      case (op)
         5'd0: r = a + b;
         5'd1: r = a - b;
         5'd2: r = a ^ b;
         5'd3: r = a | b;
         5'd4: r = a & b;
         5'd5: r = a << b[4:0];
         5'd6: r = a >> b[4:0];
         5'd7: r = $signed(a) >>> b[4:0];
         5'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         5'd9: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MDU_MULDIV_EN
         5'd16: begin p = sa * sb; r = p[31:0]; lat = 33; end
         5'd17: begin p = sa * sb; r = p[63:32]; lat = 33; end
         5'd18: begin p = sa * $signed({32'b0, b}); r = p[63:32]; lat = 33; end
         5'd19: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; lat = 33; end
         5'd20: begin
            if (b == 0) r = '1;
            else if (a == MINV && b == '1) r = MINV;
            else begin r = $signed(a) / $signed(b); lat = 33; end
         end
         5'd21: begin
            if (b == 0) r = '1;
            else begin r = a / b; lat = 33; end
         end
         5'd22: begin
            if (b == 0) r = a;
            else if (a == MINV && b == '1) r = '0;
            else begin r = $signed(a) % $signed(b); lat = 33; end
         end
         5'd23: begin
            if (b == 0) r = a;
            else begin r = a % b; lat = 33; end
         end
`endif
         default: ill = 1'b1;
      endcase
   endfunction

   // One full transaction with out_ready=1: checks latency, busy in_ready, result
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
      logic [31:0] er;
      logic ei;
      int el, lat;
      bit busy_bad;
      model(op, a, b, er, ei, el);
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s ready_before_issue: got %b want 1", name, in_ready);
      end
      op_sel = op; opdA = a; opdB = b; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; opdA = $urandom; opdB = $urandom; op_sel = 5'($urandom);
      lat = 1; busy_bad = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         if (in_ready !== 1'b0) busy_bad = 1;
         @(negedge clk);
         lat++;
      end
      tests_run++;
      if (lat != el) begin
         tests_failed++;
         $display("FAIL %s latency: got %0d want %0d (op=%0d a=%h b=%h)", name, lat, el, op, a, b);
      end
      tests_run++;
      if (out !== er || out_illegal !== ei) begin
         tests_failed++;
         $display("FAIL %s result: got out=%h ill=%b want out=%h ill=%b (op=%0d a=%h b=%h)",
                  name, out, out_illegal, er, ei, op, a, b);
      end
      tests_run++;
      if (busy_bad) begin
         tests_failed++;
         $display("FAIL %s in_ready_busy: got 1 while busy want 0", name);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== '0 || out_illegal !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: got valid=%b ready=%b out=%h ill=%b want 0 1 0 0",
                  out_valid, in_ready, out, out_illegal);
      end
      rst = 1'b0;
   endtask

   task automatic test_base_ops();
      run_op(5'd0, 32'h7FFF_FFFF, 32'd1, "add_overflow");
      run_op(5'd7, 32'h8000_0000, 32'h24, "sra_shift4");
      run_op(5'd8, 32'hFFFF_FFFF, 32'd1, "slt_neg");
      run_op(5'd9, 32'hFFFF_FFFF, 32'd1, "sltu_big");
      run_op(5'd5, 32'h0000_0001, 32'hFFFF_FFFF, "sll_31");
   endtask

   task automatic test_muldiv();
      run_op(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_m1");
      run_op(5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_m1");
      run_op(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
      run_op(5'd18, 32'hFFFF_FFFF, 32'h0000_0003, "mulhsu_mix");
      run_op(5'd20, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
      run_op(5'd22, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
      run_op(5'd21, 32'd5, 32'd0, "divu_by0");
      run_op(5'd23, 32'd5, 32'd0, "remu_by0");
      run_op(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_op(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
   endtask

   task automatic test_illegal();
      run_op(5'd10, 32'h1234_5678, 32'h9, "illegal_10");
      run_op(5'd31, 32'hDEAD_BEEF, 32'h1, "illegal_31");
      run_op(5'd16, 32'd7, 32'd6, "code16");
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      op_sel = 5'd1; opdA = 32'd5; opdB = 32'd9; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      op_sel = 5'd0; opdA = 32'd1; opdB = 32'd2;
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (out_valid !== 1'b1 || out !== 32'hFFFF_FFFC || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_hold[%0d]: got valid=%b out=%h ready=%b want 1 fffffffc 0",
                     i, out_valid, out, in_ready);
         end
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL backpressure_release: got valid=%b ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_flush();
      bit seen;
      // Flush a held result while a new op is offered in the same cycle
      @(negedge clk);
      op_sel = 5'd0; opdA = 32'd3; opdB = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; op_sel = 5'd0; opdA = 32'd1; opdB = 32'd1;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      seen = 0;
      repeat (4) begin
         if (out_valid !== 1'b0) seen = 1;
         @(negedge clk);
      end
      tests_run++;
      if (seen || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL flush_done: got valid_seen=%b ready=%b want 0 1", seen, in_ready);
      end
`ifdef ALU_MDU_MULDIV_EN
      // Flush a divide mid-iteration
      op_sel = 5'd21; opdA = 32'd1000; opdB = 32'd7; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      seen = 0;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL flush_div_ready: got %b want 1", in_ready);
      end
      repeat (40) begin
         if (out_valid !== 1'b0) seen = 1;
         @(negedge clk);
      end
      tests_run++;
      if (seen) begin
         tests_failed++;
         $display("FAIL flush_div_valid: got out_valid=1 want never");
      end
`endif
      run_op(5'd0, 32'd3, 32'd4, "add_after_flush");
   endtask

   task automatic test_rst_mid();
      @(negedge clk);
      op_sel = 5'd16; opdA = 32'd7; opdB = 32'd9; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (out !== '0 || out_illegal !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_mid: got out=%h ill=%b valid=%b ready=%b want 0 0 0 1",
                  out, out_illegal, out_valid, in_ready);
      end
      rst = 1'b0; out_ready = 1'b1;
   endtask

   function automatic logic [31:0] rand_opd();
      case ($urandom_range(5, 0))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return MINV;
         3:       return 32'($urandom_range(20, 0));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic test_random();
      logic [4:0] codes [18] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23};
      logic [4:0] op;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(7, 0) == 0) op = 5'($urandom);
         else                           op = codes[$urandom_range(17, 0)];
         run_op(op, rand_opd(), rand_opd(), "random");
      end
   endtask

   initial begin
      test_reset();
      test_base_ops();
      test_muldiv();
      test_illegal();
      test_backpressure();
      test_flush();
      test_rst_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Parametrised, sequential successor to the combinational core ALU.
- Executes the base RV32I ALU ops plus the RV32M multiply/divide ops behind a valid/ready handshake.
- Base ops complete in 1 cycle. Multiply and divide are iterative, one bit per cycle.
- Sits in the execute stage. The pipeline stalls on in_ready/out_valid and aborts an in-flight op with flush.

Parameters:
- WIDTH, 32: operand/result width in bits (power of 2, >=8).
- CNT_W, $clog2(WIDTH)+1: iteration counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  abort current op; highest priority after rst.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  block can accept an op.
- opdA  in  WIDTH  operand A (rs1).
- opdB  in  WIDTH  operand B (rs2 or immediate).
- op_sel  in  5  operation select (encoding below).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  result.
- out_illegal  out  1  op_sel was not a supported code; qualified by out_valid.

Behaviour:
- Encoding:
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - All other codes are illegal.
- Shift amount is opdB[$clog2(WIDTH)-1:0]. SLT/SLTU return a zero-extended 1/0.
- States: IDLE, MUL, DIV, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- Accept = in_valid && in_ready. On accept, opdA/opdB/op_sel are captured; the inputs may change afterwards.
- Base or illegal op: IDLE->DONE. Result registered, so out_valid rises the cycle after accept (latency 1).
  - Illegal op: out=0, out_illegal=1.
- MUL*: IDLE->MUL.
  - Sign-correct operands per op, then run WIDTH cycles of shift-add into a 2*WIDTH product.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - Latency exactly WIDTH+1 cycles accept-to-out_valid.
- DIV*: IDLE->DIV.
  - Restoring divide on magnitudes over WIDTH cycles, then sign fix-up: quotient sign = sA^sB, remainder sign = sA.
  - Latency WIDTH+1.
- Divide special cases resolve on accept, going IDLE->DONE with latency 1:
  - divisor==0: DIV/DIVU = all ones; REM/REMU = opdA.
  - Signed overflow (opdA=MIN, opdB=-1): DIV = MIN; REM = 0.
- DONE holds out/out_illegal stable until out_ready. DONE&&out_ready -> IDLE.
  - No new accept in the same cycle, so base-op throughput is 1 op per 2 cycles.
- flush in any state -> IDLE next cycle. The in-flight result is discarded, out_valid=0, and in_ready=1 the following cycle. A flush arriving in the same cycle as in_valid does not accept the op.
- rst has priority over flush. Reset values: state=IDLE, out=0, out_illegal=0, out_valid=0, in_ready=1 (combinational from state), counter=0.
- in_valid while busy is ignored. The upstream stage holds the op until in_ready.

Optional Feature:
- Macro ALU_MDU_MULDIV_EN.
- Defined: codes 16-23 execute as above.
- Undefined:
  - No multiplier/divider datapath or MUL/DIV states are built.
  - Codes 16-23 are treated as illegal: latency 1, out=0, out_illegal=1.
  - Base ops are unchanged.

Test Plan:
- WIDTH=32; ADD 0x7FFFFFFF+1 with out_ready=1 -> out_valid the cycle after accept, out=0x80000000, out_illegal=0; SRA 0x80000000 by opdB=0x24 (shift 4) -> 0xF8000000.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000 (MUL gives 0x00000001); MULHU same operands -> 0xFFFFFFFE; out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF, latency 1; DIV 0x80000000/-1 -> 0x80000000; REM of the same operands -> 0.
- Start DIVU, assert flush at iteration 10 -> out_valid never rises, in_ready=1 two cycles after flush; next ADD 3+4 -> 7.
- Backpressure: out_ready=0 for 5 cycles after a SUB 5-9 result -> out=0xFFFFFFFC held stable, in_valid ignored; out_ready=1 -> IDLE next cycle. Assert rst mid-MUL -> all outputs 0, in_ready=1.
- op_sel=10 (and, without ALU_MDU_MULDIV_EN, op_sel=16) -> out=0, out_illegal=1, latency 1.
